// File: rtl/channel_emu.sv
// channel_emu: Tx->Rx loopback emulator: rotate -> gain -> offset(+noise) -> programmable sample delay.
// Define CHANNEL_EMU_NOISE_EN to build the per-rail LFSR noise source; otherwise NOISE_SHIFT is ignored.
module channel_emu #(
    parameter int          WIDTH       = 12,
    parameter int          DELAY_DEPTH = 16,
    parameter logic [15:0] SEED_I      = 16'hACE1,
    parameter logic [15:0] SEED_Q      = 16'h1D2B,
    localparam int         DW          = $clog2(DELAY_DEPTH)
) (
    input  logic                    clk_16M384,
    input  logic                    rst_16M384,
    input  logic signed [WIDTH-1:0] in_I,
    input  logic signed [WIDTH-1:0] in_Q,
    input  logic                    in_vld,
    input  logic [1:0]              ROT_CTRL,
    input  logic [3:0]              GAIN_NUM,
    input  logic signed [WIDTH-1:0] DC_OFFSET,
    input  logic [3:0]              NOISE_SHIFT,
    input  logic [DW-1:0]           DELAY_CNT,
    input  logic                    sat_clr,
    output logic signed [WIDTH-1:0] out_I,
    output logic signed [WIDTH-1:0] out_Q,
    output logic                    out_vld,
    output logic                    sat_flag
);
    localparam int STAGES = 3;
    localparam int EW     = WIDTH + 4;
    localparam logic signed [EW-1:0] MAXV = EW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);

    function automatic logic clips(input logic signed [EW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic signed [WIDTH-1:0] clamp(input logic signed [EW-1:0] v);
        if (v > MAXV) return MAXV[WIDTH-1:0];
        if (v < MINV) return MINV[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    logic [STAGES:1]         vld_pipe;
    logic signed [WIDTH-1:0] s1_i, s1_q, s2_i, s2_q, s3_i, s3_q;

    // S1: quadrant rotation; only -MIN can overflow
    logic signed [EW-1:0]    neg_i, neg_q;
    logic signed [WIDTH-1:0] r1_i, r1_q;
    logic                    c1;
    assign neg_i = -EW'(in_I);
    assign neg_q = -EW'(in_Q);

    always_comb begin
        r1_i = in_I;
        r1_q = in_Q;
        c1   = 1'b0;
        case (ROT_CTRL)
            2'd1: begin r1_i = in_Q;         r1_q = clamp(neg_i); c1 = clips(neg_i); end
            2'd2: begin r1_i = clamp(neg_i); r1_q = clamp(neg_q); c1 = clips(neg_i) | clips(neg_q); end
            2'd3: begin r1_i = clamp(neg_q); r1_q = in_I;         c1 = clips(neg_q); end
            default: ;
        endcase
    end

    // S2: x*GAIN_NUM/4 with floor rounding
    logic signed [EW-1:0] gain, p_i, p_q;
    assign gain = EW'($signed({1'b0, GAIN_NUM}));
    assign p_i  = (EW'(s1_i) * gain) >>> 2;
    assign p_q  = (EW'(s1_q) * gain) >>> 2;

    // S3: offset plus noise, summed at full width before clamping
    logic signed [EW-1:0] n_i, n_q, y_i, y_q;
    assign y_i = EW'(s2_i) + EW'(DC_OFFSET) + n_i;
    assign y_q = EW'(s2_q) + EW'(DC_OFFSET) + n_q;

`ifdef CHANNEL_EMU_NOISE_EN
    logic [15:0] lfsr_i, lfsr_q;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            lfsr_i <= SEED_I;
            lfsr_q <= SEED_Q;
        end else if (vld_pipe[2]) begin
            lfsr_i <= lfsr_next(lfsr_i);
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign n_i = (NOISE_SHIFT == 4'd15) ? '0 : (EW'($signed(lfsr_i[WIDTH-1:0])) >>> NOISE_SHIFT);
    assign n_q = (NOISE_SHIFT == 4'd15) ? '0 : (EW'($signed(lfsr_q[WIDTH-1:0])) >>> NOISE_SHIFT);
`else
    logic unused_noise;
    assign unused_noise = ^NOISE_SHIFT;
    assign n_i = '0;
    assign n_q = '0;
`endif

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            vld_pipe <= '0;
            s1_i <= '0; s1_q <= '0;
            s2_i <= '0; s2_q <= '0;
            s3_i <= '0; s3_q <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
            s1_i <= in_vld      ? r1_i       : '0;
            s1_q <= in_vld      ? r1_q       : '0;
            s2_i <= vld_pipe[1] ? clamp(p_i) : '0;
            s2_q <= vld_pipe[1] ? clamp(p_q) : '0;
            s3_i <= vld_pipe[2] ? clamp(y_i) : '0;
            s3_q <= vld_pipe[2] ? clamp(y_q) : '0;
        end
    end

    logic sat_set;
    assign sat_set = (in_vld & c1)
                   | (vld_pipe[1] & (clips(p_i) | clips(p_q)))
                   | (vld_pipe[2] & (clips(y_i) | clips(y_q)));

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384)   sat_flag <= 1'b0;
        else if (sat_set) sat_flag <= 1'b1;
        else if (sat_clr) sat_flag <= 1'b0;
    end

    // Delay line: always written; a DELAY_CNT change drops everything except this cycle's write
    logic [DW-1:0]           wptr, dly_q, rptr;
    logic [DELAY_DEPTH-1:0]  mem_vld;
    logic signed [WIDTH-1:0] mem_i [DELAY_DEPTH];
    logic signed [WIDTH-1:0] mem_q [DELAY_DEPTH];
    logic                    dly_chg, rd_vld;

    assign dly_chg = (DELAY_CNT != dly_q);
    assign rptr    = wptr - DELAY_CNT;
    assign rd_vld  = mem_vld[rptr] & ~dly_chg;

    always_ff @(posedge clk_16M384) begin
        mem_i[wptr] <= s3_i;
        mem_q[wptr] <= s3_q;
    end

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            wptr    <= '0;
            dly_q   <= DELAY_CNT;
            mem_vld <= '0;
        end else begin
            wptr  <= wptr + DW'(1);
            dly_q <= DELAY_CNT;
            if (dly_chg) mem_vld <= '0;
            mem_vld[wptr] <= vld_pipe[3];
        end
    end

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            out_vld <= 1'b0;
            out_I   <= '0;
            out_Q   <= '0;
        end else if (DELAY_CNT == '0) begin
            out_vld <= vld_pipe[3];
            out_I   <= s3_i;
            out_Q   <= s3_q;
        end else begin
            out_vld <= rd_vld;
            out_I   <= rd_vld ? mem_i[rptr] : '0;
            out_Q   <= rd_vld ? mem_q[rptr] : '0;
        end
    end
endmodule

// File: tb/tb_channel_emu.sv
// tb_channel_emu: randomized + directed stimulus against a per-cycle arithmetic reference model.
module tb_channel_emu;
    localparam int W = 12, DEPTH = 16, NC = 4096;
    localparam int HI = 2047, LO = -2048;
    localparam int SEED_I = 16'hACE1, SEED_Q = 16'h1D2B;
`ifdef CHANNEL_EMU_NOISE_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, in_vld, clr, out_vld, sat_flag;
    logic signed [W-1:0] in_i, in_q, off, out_i, out_q;
    logic [1:0]          rot;
    logic [3:0]          gain, nsh, dly;

    channel_emu #(.WIDTH(W), .DELAY_DEPTH(DEPTH)) dut (
        .clk_16M384(clk), .rst_16M384(rst),
        .in_I(in_i), .in_Q(in_q), .in_vld(in_vld),
        .ROT_CTRL(rot), .GAIN_NUM(gain), .DC_OFFSET(off), .NOISE_SHIFT(nsh),
        .DELAY_CNT(dly), .sat_clr(clr),
        .out_I(out_i), .out_Q(out_q), .out_vld(out_vld), .sat_flag(sat_flag)
    );

    // Stimulus history indexed by clock edge number
    int a_vld[NC], a_i[NC], a_q[NC], a_rot[NC], a_gain[NC], a_off[NC];
    int a_dly[NC], a_rst[NC], a_clr[NC], a_sh[NC], a_ni[NC], a_nq[NC];
    int cyc = 0, n_chk = 0, n_err = 0, m_sat = 0;
    int lf_i = SEED_I, lf_q = SEED_Q;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q = a / b;
        if ((a % b) != 0 && a < 0) q--;
        return q;
    endfunction

    function automatic int clampc(input int v, output bit c);
        c = (v > HI) || (v < LO);
        return (v > HI) ? HI : (v < LO) ? LO : v;
    endfunction

    function automatic bit alive(input int t, input int e);
        if (t < 0 || a_vld[t] == 0) return 1'b0;
        for (int k = t; k <= e; k++) if (a_rst[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int lstep(input int l);
        int fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 16'hFFFF;
    endfunction

    function automatic int nz(input int l, input int sh);
        int v = l % 4096;
        if (v >= 2048) v -= 4096;
        return (sh == 15) ? 0 : fdiv(v, 1 << sh);
    endfunction

    // Sample entering at edge t: rotated at t, scaled at t+1, offset at t+2
    task automatic sample(input int t, output int yi, output int yq, output bit c1, output bit c2, output bit c3);
        int ri, rq, gi, gq;
        bit ca, cb;
        case (a_rot[t])
            0:       begin ri =  a_i[t]; rq =  a_q[t]; end
            1:       begin ri =  a_q[t]; rq = -a_i[t]; end
            2:       begin ri = -a_i[t]; rq = -a_q[t]; end
            default: begin ri = -a_q[t]; rq =  a_i[t]; end
        endcase
        ri = clampc(ri, ca); rq = clampc(rq, cb); c1 = ca | cb;
        gi = clampc(fdiv(ri * a_gain[t+1], 4), ca);
        gq = clampc(fdiv(rq * a_gain[t+1], 4), cb); c2 = ca | cb;
        yi = clampc(gi + a_off[t+2] + a_ni[t+2], ca);
        yq = clampc(gq + a_off[t+2] + a_nq[t+2], cb); c3 = ca | cb;
    endtask

    task automatic noise_edge(input int e);
        if (a_rst[e] != 0) begin
            lf_i = SEED_I; lf_q = SEED_Q;
        end else begin
            a_ni[e] = NOISE_ON ? nz(lf_i, a_sh[e]) : 0;
            a_nq[e] = NOISE_ON ? nz(lf_q, a_sh[e]) : 0;
            if (alive(e - 2, e)) begin lf_i = lstep(lf_i); lf_q = lstep(lf_q); end
        end
    endtask

    task automatic model_edge(input int e, output int ev, output int ei, output int eq);
        int d, t, yi, yq;
        bit c1, c2, c3, set;
        ev = 0; ei = 0; eq = 0;
        if (a_rst[e] != 0) begin m_sat = 0; return; end
        d = a_dly[e];
        t = e - 3 - d;
        if (alive(t, e)) begin
            ev = 1;
            for (int k = e - d + 1; k <= e; k++) if (a_dly[k] != a_dly[k-1]) ev = 0;
            if (ev != 0) begin sample(t, yi, yq, c1, c2, c3); ei = yi; eq = yq; end
        end
        set = 1'b0;
        if (alive(e, e))     begin sample(e,     yi, yq, c1, c2, c3); set |= c1; end
        if (alive(e - 1, e)) begin sample(e - 1, yi, yq, c1, c2, c3); set |= c2; end
        if (alive(e - 2, e)) begin sample(e - 2, yi, yq, c1, c2, c3); set |= c3; end
        if (set) m_sat = 1;
        else if (a_clr[e] != 0) m_sat = 0;
    endtask

    task automatic tick();
        int ev, ei, eq;
        a_vld[cyc] = int'(in_vld); a_i[cyc] = int'(in_i); a_q[cyc] = int'(in_q);
        a_rot[cyc] = int'(rot); a_gain[cyc] = int'(gain); a_off[cyc] = int'(off);
        a_dly[cyc] = int'(dly); a_rst[cyc] = int'(rst); a_clr[cyc] = int'(clr);
        a_sh[cyc]  = int'(nsh);
        @(posedge clk);
        #1;
        noise_edge(cyc);
        model_edge(cyc, ev, ei, eq);
        chk("out_vld",  int'(out_vld),  ev);
        chk("out_I",    int'(out_i),    ei);
        chk("out_Q",    int'(out_q),    eq);
        chk("sat_flag", int'(sat_flag), m_sat);
        cyc++;
    endtask

    task automatic one(input int i, input int q);
        in_i = W'(i); in_q = W'(q); in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_i = '0; in_q = '0; rot = 2'd0; gain = 4'd4;
        off = '0; nsh = 4'd15; dly = 4'd0; clr = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Passthrough ramp
        for (int v = -100; v <= 100; v++) begin
            in_vld = 1'b1; in_i = W'(v); in_q = W'(-v); tick();
        end
        in_vld = 1'b0;
        repeat (4) tick();
        chk("t1_sat_clear", int'(sat_flag), 0);

        // Rotation and gain
        rot = 2'd1; gain = 4'd3;
        one(400, -200); repeat (3) tick();
        chk("t2_rot1_i", int'(out_i), -150);
        chk("t2_rot1_q", int'(out_q), -300);
        rot = 2'd2; gain = 4'd4;
        one(400, -200); repeat (3) tick();
        chk("t2_rot2_i", int'(out_i), -400);
        chk("t2_rot2_q", int'(out_q), 200);
        one(-2048, 0); repeat (3) tick();
        chk("t2_negmin_i", int'(out_i), 2047);
        chk("t2_negmin_sat", int'(sat_flag), 1);

        // Saturation, clear, set-wins
        rot = 2'd0; gain = 4'd8;
        one(2000, 0); repeat (3) tick();
        chk("t3_gain_sat_i", int'(out_i), 2047);
        gain = 4'd4; clr = 1'b1;
        one(10, 0);
        clr = 1'b0;
        chk("t3_cleared", int'(sat_flag), 0);
        repeat (4) tick();
        gain = 4'd8;
        one(2000, 0);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t3_set_wins", int'(sat_flag), 1);
        gain = 4'd4;
        repeat (4) tick();

        // Delay impulse, then a delay change mid-stream
        dly = 4'd5;
        repeat (8) tick();
        one(1000, 0); repeat (8) tick();
        chk("t4_imp_vld", int'(out_vld), 1);
        chk("t4_imp_i", int'(out_i), 1000);
        tick();
        chk("t4_imp_once", int'(out_vld), 0);
        for (int n = 0; n < 40; n++) begin
            if (n == 15) dly = 4'd10;
            in_vld = 1'b1; in_i = W'($urandom_range(0, 1000)); in_q = W'(n); tick();
        end

        // Valid gating and reset mid-burst
        dly = 4'd0; in_vld = 1'b0; in_i = W'(500);
        repeat (6) tick();
        for (int n = 0; n < 16; n++) begin
            rst = (n == 7);
            in_vld = 1'b1; in_i = W'($urandom); in_q = W'($urandom); tick();
        end
        rst = 1'b0; in_vld = 1'b0;
        repeat (8) tick();

        // Randomized traffic with live config, delay changes, clears and resets
        for (int n = 0; n < 1500; n++) begin
            in_vld = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       in_i = W'(LO);
                1:       in_i = W'(HI);
                default: in_i = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       in_q = W'(LO);
                1:       in_q = W'(HI);
                default: in_q = W'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) rot  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) gain = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) off  = W'($urandom_range(0, 1) != 0 ? $urandom : $urandom_range(0, 64));
            if ($urandom_range(0, 15) == 0) nsh  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) dly  = 4'($urandom_range(0, DEPTH - 1));
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; clr = 1'b0; in_vld = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
